// File: rtl/id_regfile_pkg.sv
// Shared constants for the ID-stage integer register file.
package id_regfile_pkg;

    localparam int unsigned RF_DATA_W = 32;
    localparam int unsigned RF_ADDR_W = 5;

    localparam logic        ENABLE         = 1'b1;
    localparam logic        DISABLE        = 1'b0;
    localparam logic [31:0] DATA_INITIAL   = 32'h0000_0000;
    localparam logic [4:0]  RFADDR_INITIAL = 5'd0;
    localparam logic [4:0]  RF_ZERO_ADDR   = 5'd0;

endpackage : id_regfile_pkg

// File: rtl/id_regfile_rf_read_mux.sv
// One register-file read port: hardwired zero for x0, optional write-first bypass from WB.
module rf_read_mux
    import id_regfile_pkg::*;
#(
    parameter int unsigned DATA_W = RF_DATA_W,
    parameter int unsigned ADDR_W = RF_ADDR_W
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] entry_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              bypass_en_i,
    output logic [DATA_W-1:0] rdata_c_o
);

    // x0 reads zero; a same-cycle WB write to the read address wins over the array
    always_comb begin
        rdata_c_o = entry_i;
        if (addr_i == ADDR_W'(RF_ZERO_ADDR)) begin
            rdata_c_o = '0;
        end else if (bypass_en_i && we_i && (addr_i == waddr_i)) begin
            rdata_c_o = wdata_i;
        end
    end

endmodule : rf_read_mux

// File: rtl/id_regfile.sv
// Integer register file: two combinational ID read ports, WB write port, registered debug read.
module id_regfile
    import id_regfile_pkg::*;
#(
    parameter int unsigned DATA_W = RF_DATA_W,
    parameter int unsigned ADDR_W = RF_ADDR_W,
    parameter int unsigned BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_RFWe,
    input  logic [ADDR_W-1:0] wb_rfwaddr,
    input  logic [DATA_W-1:0] wb_rfwdata,
    input  logic [ADDR_W-1:0] rs1_addr,
    output logic [DATA_W-1:0] rs1_data,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs2_data,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_valid,
    output logic [DATA_W-1:0] dbg_rdata
);

    localparam int unsigned NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [0:NREG-1];
    logic [DATA_W-1:0] regs_d [0:NREG-1];
    logic              dbg_valid_q;
    logic              dbg_valid_d;
    logic [DATA_W-1:0] dbg_rdata_q;
    logic [DATA_W-1:0] dbg_rdata_d;
    logic [DATA_W-1:0] dbg_mux_data;
    logic              port_bypass_en;

    assign port_bypass_en = (BYPASS != 0);

    // WB write into the array; x0 is never written
    always_comb begin
        regs_d = regs_q;
        if ((wb_RFWe == ENABLE) && (wb_rfwaddr != ADDR_W'(RF_ZERO_ADDR))) begin
            regs_d[wb_rfwaddr] = wb_rfwdata;
        end
    end

    // Debug capture: valid follows the request, data holds when idle
    always_comb begin
        dbg_valid_d = DISABLE;
        dbg_rdata_d = dbg_rdata_q;
        if (dbg_req == ENABLE) begin
            dbg_valid_d = ENABLE;
            dbg_rdata_d = dbg_mux_data;
        end
    end

    // State registers; reset clears the whole array and drops any pending debug request
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= DATA_W'(DATA_INITIAL);
            end
            dbg_valid_q <= DISABLE;
            dbg_rdata_q <= DATA_W'(DATA_INITIAL);
        end else begin
            regs_q      <= regs_d;
            dbg_valid_q <= dbg_valid_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    rf_read_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rs1_mux (
        .addr_i      (rs1_addr),
        .entry_i     (regs_q[rs1_addr]),
        .we_i        (wb_RFWe),
        .waddr_i     (wb_rfwaddr),
        .wdata_i     (wb_rfwdata),
        .bypass_en_i (port_bypass_en),
        .rdata_c_o   (rs1_data)
    );

    rf_read_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rs2_mux (
        .addr_i      (rs2_addr),
        .entry_i     (regs_q[rs2_addr]),
        .we_i        (wb_RFWe),
        .waddr_i     (wb_rfwaddr),
        .wdata_i     (wb_rfwdata),
        .bypass_en_i (port_bypass_en),
        .rdata_c_o   (rs2_data)
    );

    // Debug port always sees the bypassed value, regardless of BYPASS
    rf_read_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dbg_mux (
        .addr_i      (dbg_addr),
        .entry_i     (regs_q[dbg_addr]),
        .we_i        (wb_RFWe),
        .waddr_i     (wb_rfwaddr),
        .wdata_i     (wb_rfwdata),
        .bypass_en_i (ENABLE),
        .rdata_c_o   (dbg_mux_data)
    );

    assign dbg_valid = dbg_valid_q;
    assign dbg_rdata = dbg_rdata_q;

endmodule : id_regfile

// File: tb/tb_id_regfile.sv
// Scoreboard bench for id_regfile: bypassed and non-bypassed builds driven in lockstep.
module tb_id_regfile;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    localparam logic [3:0] K_RS1   = 4'd0;
    localparam logic [3:0] K_RS2   = 4'd1;
    localparam logic [3:0] K_RS1NB = 4'd2;
    localparam logic [3:0] K_RS2NB = 4'd3;
    localparam logic [3:0] K_DBGV  = 4'd4;
    localparam logic [3:0] K_DBGR  = 4'd5;

    typedef struct packed {
        logic [3:0]    kind;
        logic [DW-1:0] exp;
    } chk_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_RFWe;
    logic [AW-1:0] wb_rfwaddr;
    logic [DW-1:0] wb_rfwdata;
    logic [AW-1:0] rs1_addr;
    logic [AW-1:0] rs2_addr;
    logic          dbg_req;
    logic [AW-1:0] dbg_addr;

    logic [DW-1:0] rs1_data, rs2_data, dbg_rdata;
    logic          dbg_valid;
    logic [DW-1:0] rs1_data_nb, rs2_data_nb, dbg_rdata_nb;
    logic          dbg_valid_nb;

    chk_t          read_q[$];
    logic [DW-1:0] dbg_q[$];
    logic [DW-1:0] dbgnb_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    id_regfile #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1)) dut (
        .clk(clk), .rst(rst),
        .wb_RFWe(wb_RFWe), .wb_rfwaddr(wb_rfwaddr), .wb_rfwdata(wb_rfwdata),
        .rs1_addr(rs1_addr), .rs1_data(rs1_data),
        .rs2_addr(rs2_addr), .rs2_data(rs2_data),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr),
        .dbg_valid(dbg_valid), .dbg_rdata(dbg_rdata)
    );

    id_regfile #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst),
        .wb_RFWe(wb_RFWe), .wb_rfwaddr(wb_rfwaddr), .wb_rfwdata(wb_rfwdata),
        .rs1_addr(rs1_addr), .rs1_data(rs1_data_nb),
        .rs2_addr(rs2_addr), .rs2_data(rs2_data_nb),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr),
        .dbg_valid(dbg_valid_nb), .dbg_rdata(dbg_rdata_nb)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic expect_rd(input logic [3:0] kind, input logic [DW-1:0] exp);
        chk_t c;
        c.kind = kind;
        c.exp  = exp;
        read_q.push_back(c);
    endtask

    task automatic drive(input logic r, input logic we, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2, input logic dq, input logic [AW-1:0] da);
        rst = r; wb_RFWe = we; wb_rfwaddr = wa; wb_rfwdata = wd;
        rs1_addr = a1; rs2_addr = a2; dbg_req = dq; dbg_addr = da;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare everything queued for this cycle against the DUT outputs
    always @(negedge clk) begin
        chk_t it;
        if (dbg_valid === 1'b1) begin
            if (dbg_q.size() == 0) begin
                n_checks++;
                $display("FAIL dbg_unexpected: dbg_valid=1 with no request outstanding (t=%0t)", $time);
            end else begin
                check("dbg_rdata", dbg_rdata, dbg_q.pop_front());
            end
        end
        if (dbg_valid_nb === 1'b1) begin
            if (dbgnb_q.size() == 0) begin
                n_checks++;
                $display("FAIL dbg_nb_unexpected: dbg_valid=1 with no request outstanding (t=%0t)", $time);
            end else begin
                check("dbg_rdata_nb", dbg_rdata_nb, dbgnb_q.pop_front());
            end
        end
        while (read_q.size() > 0) begin
            it = read_q.pop_front();
            case (it.kind)
                K_RS1:   check("rs1_data", rs1_data, it.exp);
                K_RS2:   check("rs2_data", rs2_data, it.exp);
                K_RS1NB: check("rs1_data_nb", rs1_data_nb, it.exp);
                K_RS2NB: check("rs2_data_nb", rs2_data_nb, it.exp);
                K_DBGV:  check("dbg_valid", DW'(dbg_valid), it.exp);
                default: check("dbg_rdata_hold", dbg_rdata, it.exp);
            endcase
        end
    end

    task automatic expect_dbg(input logic [DW-1:0] v);
        dbg_q.push_back(v);
        dbgnb_q.push_back(v);
    endtask

    initial begin
        int budget;
        drive(1'b1, 1'b0, '0, '0, '0, '0, 1'b0, '0);
        step();

        // 1: after reset every register reads zero, no debug result
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 1'b0, '0, '0, AW'(i), AW'(32 - i), 1'b0, '0);
            expect_rd(K_RS1, 32'h0);
            expect_rd(K_RS2, 32'h0);
            expect_rd(K_RS1NB, 32'h0);
            expect_rd(K_RS2NB, 32'h0);
            expect_rd(K_DBGV, 32'h0);
            step();
        end

        // 2: same-cycle bypass, then array read
        drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 1'b0, '0);
        expect_rd(K_RS1, 32'hDEADBEEF);
        expect_rd(K_RS2, 32'hDEADBEEF);
        expect_rd(K_RS1NB, 32'h0);
        step();
        drive(1'b0, 1'b0, 5'd5, 32'h0, 5'd5, 5'd0, 1'b0, '0);
        expect_rd(K_RS1, 32'hDEADBEEF);
        expect_rd(K_RS1NB, 32'hDEADBEEF);
        step();

        // 3: writes to x0 are dropped and never bypassed
        drive(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0, '0);
        expect_rd(K_RS1, 32'h0);
        expect_rd(K_RS2, 32'h0);
        expect_rd(K_RS1NB, 32'h0);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, '0);
        expect_rd(K_RS1, 32'h0);
        step();

        // 4: no-bypass build sees the old value until the write lands
        drive(1'b0, 1'b1, 5'd7, 32'h12345678, 5'd0, 5'd7, 1'b0, '0);
        expect_rd(K_RS2NB, 32'h0);
        expect_rd(K_RS2, 32'h12345678);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd7, 1'b0, '0);
        expect_rd(K_RS2NB, 32'h12345678);
        step();

        // 5: debug reads are bypassed, one result per cycle, data held when idle
        drive(1'b0, 1'b1, 5'd5, 32'hA5A5A5A5, 5'd0, 5'd0, 1'b1, 5'd5);
        expect_dbg(32'hA5A5A5A5);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd5);
        expect_dbg(32'hA5A5A5A5);
        step();
        drive(1'b0, 1'b1, 5'd6, 32'h00000066, 5'd0, 5'd0, 1'b1, 5'd6);
        expect_dbg(32'h00000066);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd7);
        expect_dbg(32'h12345678);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, '0);
        step();
        expect_rd(K_DBGV, 32'h0);
        expect_rd(K_DBGR, 32'h12345678);
        step();

        // 6: reset beats a same-cycle write and debug request
        drive(1'b1, 1'b1, 5'd3, 32'h33333333, 5'd0, 5'd0, 1'b1, 5'd3);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd5, 1'b0, '0);
        expect_rd(K_RS1, 32'h0);
        expect_rd(K_RS2, 32'h0);
        expect_rd(K_DBGV, 32'h0);
        expect_rd(K_DBGR, 32'h0);
        step();
        drive(1'b0, 1'b1, 5'd3, 32'hCAFEF00D, 5'd3, 5'd0, 1'b0, '0);
        expect_rd(K_RS1, 32'hCAFEF00D);
        expect_rd(K_RS1NB, 32'h0);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0, 1'b0, '0);
        expect_rd(K_RS1, 32'hCAFEF00D);
        expect_rd(K_RS1NB, 32'hCAFEF00D);
        step();

        // Drain: bounded wait for every outstanding expectation to be consumed
        budget = 20;
        while ((read_q.size() + dbg_q.size() + dbgnb_q.size()) != 0 && budget > 0) begin
            step();
            budget--;
        end
        check("dbg_q_drained", DW'(dbg_q.size()), 32'h0);
        check("dbgnb_q_drained", DW'(dbgnb_q.size()), 32'h0);
        check("read_q_drained", DW'(read_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_id_regfile
